// File: rtl/seq_shift.sv
// seq_shift: multi-cycle logical shifter that moves the operand one bit per clock
module seq_shift #(
  parameter logic [3:0] SLL = 4'b0011,
  parameter logic [3:0] SRL = 4'b0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [3:0]  signal,
  output logic        busy,
  output logic        done,
  output logic [31:0] dataOut
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [31:0] shift_reg, shifted;
  logic [4:0] count;
  logic [3:0] op;
  logic accept, unused_b;
  always_comb begin
    accept = start && state != SHIFT;
    shifted = (op == SLL && SLL != SRL) ? {shift_reg[30:0], 1'b0} : {1'b0, shift_reg[31:1]};
    state_nxt = accept ? (dataB[4:0] == 5'd0 ? DONE : SHIFT)
              : state == SHIFT ? (count == 5'd1 ? DONE : SHIFT) : IDLE;
    unused_b = ^dataB[31:5];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      shift_reg <= '0;
      count <= '0;
      op <= '0;
      dataOut <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        shift_reg <= dataA;
        count <= dataB[4:0];
        op <= signal;
      end else if (state == SHIFT) begin
        shift_reg <= shifted;
        count <= count - 5'd1;
      end
      if (state_nxt == DONE) dataOut <= accept ? dataA : shifted;
    end
  end
  assign busy = state == SHIFT;
  assign done = state == DONE;
endmodule

// File: tb/tb_seq_shift.sv
// tb_seq_shift: directed checks of latency, result, busy/done and reset behaviour
module tb_seq_shift;
  logic clk = 0;
  logic reset, start;
  logic [31:0] dataA, dataB;
  logic [3:0] signal;
  logic busy, done;
  logic [31:0] dataOut;
  int vectors = 0;
  int miscompares = 0;

  seq_shift dut (
    .clk(clk), .reset(reset), .start(start), .dataA(dataA), .dataB(dataB),
    .signal(signal), .busy(busy), .done(done), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] s, input int n, input logic [31:0] exp,
                        input bit pre, input bit post, input int rp);
    int lat, busy_cnt;
    bit bad_hold, overlap;
    logic [31:0] prev;
    lat = 0;
    busy_cnt = 0;
    bad_hold = 0;
    overlap = 0;
    if (!pre) @(negedge clk);
    prev = dataOut;
    start = 1;
    dataA = a;
    dataB = b;
    signal = s;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      @(negedge clk);
      start = (i == rp);
      if (i == rp) begin
        dataA = 32'hFFFF_FFFF;
        dataB = 32'd2;
        signal = 4'b0100;
      end
      if (busy && done) overlap = 1;
      if (busy) begin
        busy_cnt++;
        if (dataOut !== prev) bad_hold = 1;
      end
      if (done) lat = i;
    end
    check({tag, " latency"}, lat, n + 1);
    check({tag, " busy cycles"}, busy_cnt, n);
    check({tag, " dataOut"}, dataOut, exp);
    check({tag, " busy&done"}, {31'b0, overlap}, 32'd0);
    check({tag, " hold"}, {31'b0, bad_hold}, 32'd0);
    if (post) begin
      @(negedge clk);
      check({tag, " done pulse"}, {31'b0, done}, 32'd0);
    end
  endtask

  initial begin
    int busy_cnt;
    bit seen;
    reset = 1;
    start = 1;
    dataA = 32'h1234_5678;
    dataB = 32'd0;
    signal = 4'b0011;
    repeat (2) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset dataOut", dataOut, 32'd0);
    reset = 0;
    start = 0;
    run_op("sll5", 32'h0000_0001, 32'd5, 4'b0011, 5, 32'h0000_0020, 0, 1, 0);
    run_op("srl31", 32'h8000_0000, 32'd31, 4'b0100, 31, 32'h0000_0001, 0, 1, 0);
    run_op("srl3hi", 32'hF000_0000, 32'hFFFF_FFE3, 4'b0100, 3, 32'h1E00_0000, 0, 1, 0);
    run_op("zero", 32'hDEAD_BEEF, 32'd0, 4'b1111, 0, 32'hDEAD_BEEF, 0, 1, 0);
    run_op("dflt4", 32'hDEAD_BEEF, 32'd4, 4'b1111, 4, 32'h0DEA_DBEE, 0, 1, 0);
    run_op("ignore", 32'h0000_0001, 32'd8, 4'b0011, 8, 32'h0000_0100, 0, 1, 3);
    run_op("b2b_a", 32'h1234_5678, 32'd2, 4'b0011, 2, 32'h48D1_59E0, 0, 0, 0);
    run_op("b2b_b", 32'h0000_00F0, 32'd4, 4'b0100, 4, 32'h0000_000F, 1, 1, 0);
    @(negedge clk);
    start = 1;
    dataA = 32'h0000_0001;
    dataB = 32'd20;
    signal = 4'b0011;
    busy_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 0;
      if (busy) busy_cnt++;
      if (i == 10) begin
        reset = 1;
        start = 1;
        dataA = 32'h0000_0055;
        dataB = 32'd0;
      end
    end
    check("abort busy cycles", busy_cnt, 32'd10);
    @(negedge clk);
    reset = 0;
    start = 0;
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    check("abort dataOut", dataOut, 32'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check("abort no done", {31'b0, seen}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
